sakebi_axis_tx_arb: RTL and testbench

Frame-atomic round-robin arbiter that shares one AXI-Stream byte path (toward the RMII TX side) between N_REQ frame sources, such as ARP responder and UDP sender.
- Grants one source per frame and forwards its beats with zero added data latency.
- Enforces an inter-frame gap after each frame.
- Aborts frames whose source stalls too long mid-frame.

---
 rtl/sakebi_pkg.sv | 18 +
 rtl/sakebi_rr_pick.sv | 32 +++
 rtl/sakebi_axis_tx_arb.sv | 134 +++++++++++++
 tb/tb_sakebi_axis_tx_arb.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sakebi_pkg.sv
// Shared types and constants for the sakebi stream arbiters.
package sakebi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int ETH_IFG_BYTES = 12;

  // Counter/index width that stays >= 1 bit for degenerate sizes.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sakebi_rr_pick.sv
// Round-robin pick: first set request scanning ptr, ptr+1, ... mod N.
module sakebi_rr_pick
  import sakebi_pkg::*;
#(
  parameter  int N  = 2,
  localparam int PW = cw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] k;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    k    = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any     = 1'b1;
        pick[k] = 1'b1;
        idx     = k;
      end
    end
  end

endmodule

// File: rtl/sakebi_axis_tx_arb.sv
// Frame-atomic round-robin AXI-Stream arbiter with inter-frame gap and
// mid-frame stall watchdog that closes a stalled frame with a TUSER-marked beat.
module sakebi_axis_tx_arb
  import sakebi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 2,
  parameter int IFG_CYCLES = ETH_IFG_BYTES,
  parameter int STALL_MAX  = 255
) (
  input  logic                        i_axis_ACLK,
  input  logic                        i_axis_ARESETn,
  input  logic [N_REQ-1:0]            i_s_axis_TVALID,
  output logic [N_REQ-1:0]            o_s_axis_TREADY,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_s_axis_TDATA,
  input  logic [N_REQ-1:0]            i_s_axis_TLAST,
  output logic                        o_m_axis_TVALID,
  input  logic                        i_m_axis_TREADY,
  output logic [DATA_WIDTH-1:0]       o_m_axis_TDATA,
  output logic                        o_m_axis_TLAST,
  output logic                        o_m_axis_TUSER,
  output logic [N_REQ-1:0]            o_grant,
  output logic                        o_err_stall
);

  localparam int PW = cw(N_REQ);
  localparam int GW = cw(IFG_CYCLES + 1);
  localparam int SW = cw(STALL_MAX + 1);
  localparam state_t ST_DONE = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_t              state, state_nxt;
  logic [PW-1:0]       ptr, gidx, ptr_nxt, pick_idx;
  logic [N_REQ-1:0]    grant, pick;
  logic                pick_any;
  logic [GW-1:0]       gap_cnt;
  logic [SW-1:0]       stall_cnt;
  logic                err_stall;
  logic [DATA_WIDTH-1:0] s_data [N_REQ];
  logic                g_valid, g_last, beat_end, stall_hit, gap_done;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign s_data[k] = i_s_axis_TDATA[k*DATA_WIDTH +: DATA_WIDTH];
  end

  sakebi_rr_pick #(.N(N_REQ)) u_pick (
    .req  (i_s_axis_TVALID),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign g_valid   = i_s_axis_TVALID[gidx];
  assign g_last    = i_s_axis_TLAST[gidx];
  assign beat_end  = g_valid && i_m_axis_TREADY && g_last;
  // Only source silence counts toward the watchdog; downstream backpressure does not.
  assign stall_hit = (STALL_MAX != 0) && !g_valid && (stall_cnt == SW'(STALL_MAX - 1));
  assign gap_done  = (gap_cnt == GW'(IFG_CYCLES - 1));
  assign ptr_nxt   = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_nxt       = state;
    o_m_axis_TVALID = 1'b0;
    o_m_axis_TDATA  = '0;
    o_m_axis_TLAST  = 1'b0;
    o_m_axis_TUSER  = 1'b0;
    o_s_axis_TREADY = '0;
    case (state)
      ST_IDLE: if (pick_any) state_nxt = ST_XFER;
      ST_XFER: begin
        o_m_axis_TVALID = g_valid;
        o_m_axis_TDATA  = s_data[gidx];
        o_m_axis_TLAST  = g_last;
        o_s_axis_TREADY = grant & {N_REQ{i_m_axis_TREADY}};
        if (beat_end)       state_nxt = ST_DONE;
        else if (stall_hit) state_nxt = ST_ABORT;
      end
      ST_ABORT: begin
        o_m_axis_TVALID = 1'b1;
        o_m_axis_TLAST  = 1'b1;
        o_m_axis_TUSER  = 1'b1;
        if (i_m_axis_TREADY) state_nxt = ST_DONE;
      end
      ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      gap_cnt   <= '0;
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_stall <= 1'b0;
      case (state)
        ST_IDLE: if (pick_any) begin
          grant <= pick;
          gidx  <= pick_idx;
        end
        ST_XFER: begin
          err_stall <= stall_hit;
          if (beat_end) begin
            ptr       <= ptr_nxt;
            grant     <= '0;
            stall_cnt <= '0;
          end else if (g_valid) begin
            stall_cnt <= '0;
          end else if (STALL_MAX != 0 && stall_cnt != SW'(STALL_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          stall_cnt <= '0;
          if (i_m_axis_TREADY) begin
            ptr   <= ptr_nxt;
            grant <= '0;
          end
        end
        ST_GAP:  gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign o_grant     = grant;
  assign o_err_stall = err_stall;

endmodule

// File: tb/tb_sakebi_axis_tx_arb.sv
// Directed bench: instance A (IFG 3, watchdog 5) and B (IFG 0, watchdog 2) share stimulus.
module tb_sakebi_axis_tx_arb;

  typedef struct packed { logic hole; logic last; logic [7:0] data; } ent_t;
  typedef struct { int cyc; logic [7:0] data; logic last; logic user; logic [1:0] grant; } obs_t;

  logic        clk = 1'b0, rst_n = 1'b0, m_ready = 1'b1, use_b = 1'b0, bp_mode = 1'b0;
  logic [1:0]  s_valid = '0, s_last = '0;
  logic [15:0] s_data = '0;
  logic [1:0]  a_s_ready, b_s_ready, a_grant, b_grant;
  logic        a_m_valid, a_m_last, a_m_user, a_err, b_m_valid, b_m_last, b_m_user, b_err;
  logic [7:0]  a_m_data, b_m_data;
  logic [1:0]  sel_s_ready, sel_grant;
  logic        sel_m_valid, sel_m_last, sel_m_user, sel_err;
  logic [7:0]  sel_m_data;
  logic [3:0]  bp_pat = 4'b1001;

  ent_t q0[$], q1[$];
  obs_t obs[$];
  int   cyc, err_cnt, err_cyc, n_cmp, n_bad;

  always #5 clk = ~clk;

  sakebi_axis_tx_arb #(.DATA_WIDTH(8), .N_REQ(2), .IFG_CYCLES(3), .STALL_MAX(5)) dut_a (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_s_axis_TVALID(s_valid), .o_s_axis_TREADY(a_s_ready), .i_s_axis_TDATA(s_data),
    .i_s_axis_TLAST(s_last), .o_m_axis_TVALID(a_m_valid), .i_m_axis_TREADY(m_ready),
    .o_m_axis_TDATA(a_m_data), .o_m_axis_TLAST(a_m_last), .o_m_axis_TUSER(a_m_user),
    .o_grant(a_grant), .o_err_stall(a_err));

  sakebi_axis_tx_arb #(.DATA_WIDTH(8), .N_REQ(2), .IFG_CYCLES(0), .STALL_MAX(2)) dut_b (
    .i_axis_ACLK(clk), .i_axis_ARESETn(rst_n),
    .i_s_axis_TVALID(s_valid), .o_s_axis_TREADY(b_s_ready), .i_s_axis_TDATA(s_data),
    .i_s_axis_TLAST(s_last), .o_m_axis_TVALID(b_m_valid), .i_m_axis_TREADY(m_ready),
    .o_m_axis_TDATA(b_m_data), .o_m_axis_TLAST(b_m_last), .o_m_axis_TUSER(b_m_user),
    .o_grant(b_grant), .o_err_stall(b_err));

  always_comb begin
    sel_s_ready = use_b ? b_s_ready : a_s_ready;
    sel_grant   = use_b ? b_grant   : a_grant;
    sel_m_valid = use_b ? b_m_valid : a_m_valid;
    sel_m_data  = use_b ? b_m_data  : a_m_data;
    sel_m_last  = use_b ? b_m_last  : a_m_last;
    sel_m_user  = use_b ? b_m_user  : a_m_user;
    sel_err     = use_b ? b_err     : a_err;
  end

  function automatic ent_t bt(input logic [7:0] d, input logic l);
    ent_t e;
    e.hole = 1'b0; e.last = l; e.data = d;
    return e;
  endfunction

  function automatic ent_t hole();
    ent_t e;
    e.hole = 1'b1; e.last = 1'b0; e.data = 8'h00;
    return e;
  endfunction

  task automatic drive_src();
    if (q0.size() > 0) begin
      s_valid[0] = !q0[0].hole; s_data[7:0] = q0[0].data; s_last[0] = q0[0].last;
    end else begin
      s_valid[0] = 1'b0; s_data[7:0] = 8'h00; s_last[0] = 1'b0;
    end
    if (q1.size() > 0) begin
      s_valid[1] = !q1[0].hole; s_data[15:8] = q1[0].data; s_last[1] = q1[0].last;
    end else begin
      s_valid[1] = 1'b0; s_data[15:8] = 8'h00; s_last[1] = 1'b0;
    end
  endtask

  // One clock: sample at negedge, advance sources just after posedge.
  task automatic step();
    logic hs0, hs1;
    obs_t o;
    @(negedge clk);
    if (sel_m_valid && m_ready) begin
      o.cyc = cyc; o.data = sel_m_data; o.last = sel_m_last; o.user = sel_m_user; o.grant = sel_grant;
      obs.push_back(o);
    end
    if (sel_err) begin err_cnt++; err_cyc = cyc; end
    hs0 = s_valid[0] && sel_s_ready[0];
    hs1 = s_valid[1] && sel_s_ready[1];
    @(posedge clk); #1;
    if (q0.size() > 0 && (hs0 || q0[0].hole)) void'(q0.pop_front());
    if (q1.size() > 0 && (hs1 || q1[0].hole)) void'(q1.pop_front());
    cyc++;
    m_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    drive_src();
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin step(); k++; end
    ok = (obs.size() >= n);
  endtask

  task automatic do_reset(input logic b);
    rst_n = 1'b0; use_b = b; bp_mode = 1'b0; m_ready = 1'b1;
    q0.delete(); q1.delete(); obs.delete();
    cyc = 0; err_cnt = 0; err_cyc = -1;
    drive_src();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({a_m_valid, a_m_last, a_m_user, a_m_data, a_s_ready, a_grant, a_err} !== 16'h0) begin
      n_bad++; $display("FAIL reset_state_a got %h want 0", {a_m_valid, a_m_last, a_m_user, a_m_data, a_s_ready, a_grant, a_err}); end
    n_cmp++; if ({b_m_valid, b_m_last, b_m_user, b_m_data, b_s_ready, b_grant, b_err} !== 16'h0) begin
      n_bad++; $display("FAIL reset_state_b got %h want 0", {b_m_valid, b_m_last, b_m_user, b_m_data, b_s_ready, b_grant, b_err}); end
    do_reset(1'b0);
    // S0 finishes a frame so the pointer moves to 1, then S1 starts a frame.
    q0.push_back(bt(8'h11, 1'b1)); drive_src();
    run_until(1, 10, ok);
    q1.push_back(bt(8'h21, 1'b0)); q1.push_back(bt(8'h22, 1'b0)); q1.push_back(bt(8'h23, 1'b1));
    drive_src();
    run_until(2, 20, ok);
    n_cmp++; if (!ok || obs[1].data !== 8'h21) begin
      n_bad++; $display("FAIL reset_preframe got %0d beats want 2 with S1 data 21", obs.size()); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({a_m_valid, a_s_ready, a_grant} !== 5'b0) begin
      n_bad++; $display("FAIL reset_midframe got %b want 00000", {a_m_valid, a_s_ready, a_grant}); end
    q0.delete(); q1.delete(); obs.delete(); drive_src();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q0.push_back(bt(8'h31, 1'b1)); q1.push_back(bt(8'h41, 1'b1)); drive_src();
    run_until(1, 10, ok);
    n_cmp++; if (!ok || obs[0].grant !== 2'b01 || obs[0].data !== 8'h31) begin
      n_bad++; $display("FAIL reset_first_grant got %0d beats first grant %b want 01 data 31", obs.size(), ok ? obs[0].grant : 2'bxx); end
  endtask

  task automatic test_contention();
    bit ok;
    logic [7:0] ed;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(bt(8'(8'hA0 + i), i == 3));
      q1.push_back(bt(8'(8'hB0 + i), i == 3));
    end
    drive_src();
    run_until(8, 60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL contention_timeout got %0d beats want 8", obs.size()); return; end
    for (int i = 0; i < 8; i++) begin
      ed = (i < 4) ? 8'(8'hA0 + i) : 8'(8'hB0 + i - 4);
      n_cmp++; if (obs[i].data !== ed || obs[i].last !== (i == 3 || i == 7) || obs[i].user !== 1'b0 ||
                   obs[i].grant !== ((i < 4) ? 2'b01 : 2'b10)) begin
        n_bad++; $display("FAIL contention_beat%0d got d=%h l=%b u=%b g=%b want d=%h", i, obs[i].data,
                          obs[i].last, obs[i].user, obs[i].grant, ed); end
    end
    // Three gap cycles plus the one-cycle arbitration in IDLE separate the frames.
    n_cmp++; if (obs[4].cyc - obs[3].cyc !== 5) begin
      n_bad++; $display("FAIL contention_gap got %0d want 5", obs[4].cyc - obs[3].cyc); end
    n_cmp++; if (obs[3].cyc - obs[0].cyc !== 3) begin
      n_bad++; $display("FAIL contention_burst got %0d want 3", obs[3].cyc - obs[0].cyc); end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [7:0] ed [6];
    logic [1:0] eg [6];
    ed = '{8'h50, 8'h51, 8'h60, 8'h61, 8'h52, 8'h53};
    eg = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    do_reset(1'b0);
    q0.push_back(bt(8'h50, 1'b0)); q0.push_back(bt(8'h51, 1'b1));
    q0.push_back(bt(8'h52, 1'b0)); q0.push_back(bt(8'h53, 1'b1));
    q1.push_back(hole()); q1.push_back(hole());
    q1.push_back(bt(8'h60, 1'b0)); q1.push_back(bt(8'h61, 1'b1));
    drive_src();
    run_until(6, 80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fairness_timeout got %0d beats want 6", obs.size()); return; end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (obs[i].data !== ed[i] || obs[i].grant !== eg[i]) begin
        n_bad++; $display("FAIL fairness_beat%0d got d=%h g=%b want d=%h g=%b", i, obs[i].data, obs[i].grant, ed[i], eg[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1);
    bp_mode = 1'b1; m_ready = bp_pat[0];
    for (int i = 0; i < 4; i++) q0.push_back(bt(8'(8'h80 + i), i == 3));
    drive_src();
    repeat (20) step();
    n_cmp++; if (obs.size() !== 4) begin
      n_bad++; $display("FAIL backpressure_count got %0d want 4", obs.size()); return; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs[i].data !== 8'(8'h80 + i) || obs[i].last !== (i == 3) || obs[i].user !== 1'b0) begin
        n_bad++; $display("FAIL backpressure_beat%0d got d=%h l=%b want d=%h", i, obs[i].data, obs[i].last, 8'(8'h80 + i)); end
    end
    n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL backpressure_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    do_reset(1'b0);
    q0.push_back(bt(8'h70, 1'b0)); q0.push_back(bt(8'h71, 1'b0));
    repeat (8) q0.push_back(hole());
    q0.push_back(bt(8'h72, 1'b1));
    drive_src();
    run_until(4, 60, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout got %0d beats want 4", obs.size()); return; end
    n_cmp++; if (obs[0].data !== 8'h70 || obs[1].data !== 8'h71 || obs[1].last !== 1'b0) begin
      n_bad++; $display("FAIL stall_head got %h %h want 70 71", obs[0].data, obs[1].data); end
    // Five silent cycles follow 0x71; the abort beat lands on the next cycle.
    n_cmp++; if (obs[2].cyc - obs[1].cyc !== 6 || obs[2].data !== 8'h00 || obs[2].last !== 1'b1 || obs[2].user !== 1'b1) begin
      n_bad++; $display("FAIL stall_abort_beat got dc=%0d d=%h l=%b u=%b want 6 00 1 1", obs[2].cyc - obs[1].cyc,
                        obs[2].data, obs[2].last, obs[2].user); end
    n_cmp++; if (err_cnt !== 1 || err_cyc !== obs[2].cyc) begin
      n_bad++; $display("FAIL stall_err got n=%0d at %0d want 1 at %0d", err_cnt, err_cyc, obs[2].cyc); end
    n_cmp++; if (obs[3].data !== 8'h72 || obs[3].user !== 1'b0 || obs[3].cyc - obs[2].cyc !== 5) begin
      n_bad++; $display("FAIL stall_resume got d=%h u=%b dc=%0d want 72 0 5", obs[3].data, obs[3].user, obs[3].cyc - obs[2].cyc); end
  endtask

  task automatic test_ifg0();
    bit ok;
    logic [7:0] ed [4];
    logic [1:0] eg [4];
    ed = '{8'h90, 8'hA5, 8'h91, 8'hA6};
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset(1'b1);
    q0.push_back(bt(8'h90, 1'b1)); q0.push_back(bt(8'h91, 1'b1));
    q1.push_back(bt(8'hA5, 1'b1)); q1.push_back(bt(8'hA6, 1'b1));
    drive_src();
    run_until(4, 30, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ifg0_timeout got %0d beats want 4", obs.size()); return; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs[i].data !== ed[i] || obs[i].grant !== eg[i] || obs[i].last !== 1'b1 ||
                   (i > 0 && obs[i].cyc - obs[i-1].cyc !== 2)) begin
        n_bad++; $display("FAIL ifg0_beat%0d got d=%h g=%b l=%b want d=%h g=%b l=1", i, obs[i].data,
                          obs[i].grant, obs[i].last, ed[i], eg[i]); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_contention();
    test_fairness();
    test_backpressure();
    test_stall();
    test_ifg0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
